jhash_key_packer: RTL and testbench

- Upstream feeder for the Jenkins lookup3 hash pipeline.
- Accepts a key as a byte stream with a valid/ready handshake and a last marker.
- Packs the bytes into 12-byte blocks (k0/k1/k2), zero-pads the final partial block, and tags each block with its byte count, last flag and total key length.
- The round pipeline consumes each block directly, one block per output transfer.

---
 rtl/jhash_pkg.sv | 28 ++
 rtl/jhash_key_packer.sv | 169 ++++++++++++++++
 tb/tb_jhash_key_packer.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jhash_pkg.sv
// Shared definitions for the Jenkins lookup3 hash front end.
// Holds block geometry, the lookup3 seed constant, key-length defaults,
// the block header that travels with each 12-byte block, and the packer
// key-context state encoding.
package jhash_pkg;

  localparam int unsigned BLK_BYTES      = 12;
  localparam int unsigned BLK_BITS       = BLK_BYTES * 8;
  localparam logic [31:0] JHASH_INIT     = 32'hDEADBEEF;
  localparam int unsigned MAXLEN_DEFAULT = 250;
  localparam int unsigned LENW_DEFAULT   = 8;
  localparam int unsigned BLENW          = 4;

  // Block header shared by the packer and the round pipeline
  typedef struct packed {
    logic [BLENW-1:0]        blen;
    logic                    last;
    logic [LENW_DEFAULT-1:0] klen;
    logic                    oflow;
  } blk_hdr_t;

  // Key context: packing bytes, or discarding bytes past the length limit
  typedef enum logic {
    ST_FILL = 1'b0,
    ST_DROP = 1'b1
  } pack_state_e;

endpackage

// File: rtl/jhash_key_packer.sv
// Byte-stream to 12-byte block packer feeding the lookup3 round pipeline.
// Bytes land little-endian in lanes 0..11 (k0 = lanes 0-3, k1 = 4-7,
// k2 = 8-11); the final partial block is zero-padded. Keys longer than
// MAXLEN are truncated, the tail is discarded and the last block is
// flagged with out_oflow.
// Ports:
//   CLK, RST                       clock, synchronous active-high reset
//   in_valid/in_ready/in_byte/in_last   byte stream input
//   out_valid/out_ready            block handshake
//   out_k0/out_k1/out_k2           packed block data
//   out_blen/out_last/out_klen/out_oflow  block header
// LENW must not exceed jhash_pkg::LENW_DEFAULT (header klen width).
module jhash_key_packer
  import jhash_pkg::*;
#(
  parameter int unsigned MAXLEN = MAXLEN_DEFAULT,
  parameter int unsigned LENW   = LENW_DEFAULT
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [7:0]      in_byte,
  input  logic            in_last,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_k0,
  output logic [31:0]     out_k1,
  output logic [31:0]     out_k2,
  output logic [3:0]      out_blen,
  output logic            out_last,
  output logic [LENW-1:0] out_klen,
  output logic            out_oflow
);

  localparam logic [LENW-1:0]  MAXLEN_L  = LENW'(MAXLEN);
  localparam logic [BLENW-1:0] LAST_LANE = BLENW'(BLK_BYTES - 1);

  pack_state_e         r_state,      w_state_nxt;
  logic [BLK_BITS-1:0] r_acc,        w_acc_nxt;
  logic [BLENW-1:0]    r_lane,       w_lane_nxt;
  logic [LENW-1:0]     r_len,        w_len_nxt;
  logic                r_hold,       w_hold_nxt;
  blk_hdr_t            r_hold_hdr,   w_hold_hdr_nxt;
  logic                r_out_valid,  w_out_valid_nxt;
  logic [BLK_BITS-1:0] r_out_k,      w_out_k_nxt;
  blk_hdr_t            r_out_hdr,    w_out_hdr_nxt;

  logic                w_byte_fire;
  logic                w_drain;
  logic                w_out_free;
  logic                w_store;
  logic                w_complete;
  logic [LENW-1:0]     w_len_inc;
  logic [BLK_BITS-1:0] w_blk_k;
  blk_hdr_t            w_blk_hdr;

  // A completed block that found the output register busy waits in the
  // accumulator (r_hold); input stalls only while such a block waits, or
  // while discarding with the output register occupied.
  assign in_ready    = ~(r_out_valid & (r_hold | (r_state == ST_DROP)));
  assign w_byte_fire = in_valid & in_ready;
  assign w_drain     = r_out_valid & out_ready;
  assign w_out_free  = ~r_out_valid | out_ready;
  assign w_len_inc   = r_len + LENW'(1);

  // State register
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state     <= ST_FILL;
      r_acc       <= '0;
      r_lane      <= '0;
      r_len       <= '0;
      r_hold      <= 1'b0;
      r_hold_hdr  <= '0;
      r_out_valid <= 1'b0;
      r_out_k     <= '0;
      r_out_hdr   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_acc       <= w_acc_nxt;
      r_lane      <= w_lane_nxt;
      r_len       <= w_len_nxt;
      r_hold      <= w_hold_nxt;
      r_hold_hdr  <= w_hold_hdr_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_k     <= w_out_k_nxt;
      r_out_hdr   <= w_out_hdr_nxt;
    end
  end

  // Packing, completion and output-register next state
  always_comb begin
    w_state_nxt     = r_state;
    w_acc_nxt       = r_acc;
    w_lane_nxt      = r_lane;
    w_len_nxt       = r_len;
    w_hold_nxt      = r_hold;
    w_hold_hdr_nxt  = r_hold_hdr;
    w_out_valid_nxt = r_out_valid;
    w_out_k_nxt     = r_out_k;
    w_out_hdr_nxt   = r_out_hdr;
    w_store         = 1'b0;
    w_complete      = 1'b0;
    w_blk_k         = r_acc;
    w_blk_hdr       = '0;

    if (w_drain) begin
      w_out_valid_nxt = 1'b0;
    end

    // Waiting block moves out as soon as the register drains
    if (r_hold && w_drain) begin
      w_out_valid_nxt = 1'b1;
      w_out_k_nxt     = r_acc;
      w_out_hdr_nxt   = r_hold_hdr;
      w_hold_nxt      = 1'b0;
      w_acc_nxt       = '0;
    end

    if (w_byte_fire) begin
      w_store        = (r_state == ST_FILL) && (r_len != MAXLEN_L);
      w_blk_hdr.last = in_last;
      if (w_store) begin
        w_blk_k            = r_acc | (BLK_BITS'(in_byte) << {r_lane, 3'b000});
        w_acc_nxt          = w_blk_k;
        w_lane_nxt         = r_lane + BLENW'(1);
        w_len_nxt          = w_len_inc;
        w_complete         = (r_lane == LAST_LANE) | in_last;
        w_blk_hdr.blen     = r_lane + BLENW'(1);
        w_blk_hdr.klen     = in_last ? LENW_DEFAULT'(w_len_inc) : '0;
      end else begin
        // Byte beyond the limit: discard; only the terminator emits
        w_complete         = in_last;
        w_blk_hdr.blen     = r_lane;
        w_blk_hdr.klen     = in_last ? LENW_DEFAULT'(r_len) : '0;
        w_blk_hdr.oflow    = in_last;
        w_state_nxt        = in_last ? ST_FILL : ST_DROP;
      end

      if (w_complete) begin
        w_lane_nxt = '0;
        if (in_last) begin
          w_len_nxt = '0;
        end
        if (w_out_free) begin
          w_out_valid_nxt = 1'b1;
          w_out_k_nxt     = w_blk_k;
          w_out_hdr_nxt   = w_blk_hdr;
          w_acc_nxt       = '0;
        end else begin
          w_hold_nxt      = 1'b1;
          w_hold_hdr_nxt  = w_blk_hdr;
          w_acc_nxt       = w_blk_k;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_k0    = r_out_k[31:0];
  assign out_k1    = r_out_k[63:32];
  assign out_k2    = r_out_k[95:64];
  assign out_blen  = r_out_hdr.blen;
  assign out_last  = r_out_hdr.last;
  assign out_klen  = LENW'(r_out_hdr.klen);
  assign out_oflow = r_out_hdr.oflow;

endmodule

// File: tb/tb_jhash_key_packer.sv
// Bench for jhash_key_packer: three instances (MAXLEN 250, 20, 24) share one
// driver, selected by sel. A key-level model turns each key into its list of
// expected blocks; a negedge monitor checks every block transfer and the
// stability of stalled blocks.
`timescale 1ns/1ps
module tb_jhash_key_packer;

  localparam int NDUT = 3;

  typedef struct {
    logic [95:0] k;
    int          blen;
    bit          last;
    int          klen;
    bit          oflow;
  } exp_t;

  function automatic int unsigned dut_maxlen(input int g);
    return (g == 0) ? 250 : ((g == 1) ? 20 : 24);
  endfunction

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_byte = 8'h00;
  logic       in_last = 1'b0;
  logic       out_ready = 1'b0;
  int         sel = 0;
  int         rdy_mode = 0;

  logic        d_in_ready  [NDUT];
  logic        d_out_valid [NDUT];
  logic [31:0] d_k0        [NDUT];
  logic [31:0] d_k1        [NDUT];
  logic [31:0] d_k2        [NDUT];
  logic [3:0]  d_blen      [NDUT];
  logic        d_last      [NDUT];
  logic [7:0]  d_klen      [NDUT];
  logic        d_oflow     [NDUT];

  logic        m_in_ready, m_out_valid, m_last, m_oflow;
  logic [95:0] m_k;
  logic [3:0]  m_blen;
  logic [7:0]  m_klen;

  int   n_checks = 0;
  int   n_errors = 0;
  int   n_blk = 0;
  int   n_acc = 0;
  exp_t exp_q[$];

  always #5 CLK = ~CLK;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    jhash_key_packer #(.MAXLEN(dut_maxlen(g)), .LENW(8)) u_dut (
      .CLK      (CLK),
      .RST      (RST),
      .in_valid (in_valid && (sel == g)),
      .in_ready (d_in_ready[g]),
      .in_byte  (in_byte),
      .in_last  (in_last),
      .out_valid(d_out_valid[g]),
      .out_ready(out_ready && (sel == g)),
      .out_k0   (d_k0[g]),
      .out_k1   (d_k1[g]),
      .out_k2   (d_k2[g]),
      .out_blen (d_blen[g]),
      .out_last (d_last[g]),
      .out_klen (d_klen[g]),
      .out_oflow(d_oflow[g])
    );
  end

  always_comb begin
    m_in_ready  = d_in_ready[sel];
    m_out_valid = d_out_valid[sel];
    m_k         = {d_k2[sel], d_k1[sel], d_k0[sel]};
    m_blen      = d_blen[sel];
    m_last      = d_last[sel];
    m_klen      = d_klen[sel];
    m_oflow     = d_oflow[sel];
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s", name);
  endtask

  // Key-level model: stored prefix split into 12-byte chunks, little-endian lanes
  function automatic void model_blocks(input logic [7:0] key[$], input int maxlen,
                                       output exp_t blks[$]);
    int   n      = key.size();
    int   stored = (n > maxlen) ? maxlen : n;
    bit   ov     = (n > maxlen);
    int   nblk   = (stored + 11) / 12;
    bit   tail   = (stored % 12) != 0;
    exp_t e;
    blks = {};
    for (int b = 0; b < nblk; b++) begin
      e.k    = '0;
      e.blen = (stored - 12 * b > 12) ? 12 : stored - 12 * b;
      for (int j = 0; j < e.blen; j++) e.k[8*j +: 8] = key[12*b + j];
      e.last  = (b == nblk - 1) && (!ov || tail);
      e.klen  = e.last ? stored : 0;
      e.oflow = e.last && ov;
      blks.push_back(e);
    end
    if (ov && !tail) begin
      e.k = '0; e.blen = 0; e.last = 1'b1; e.klen = stored; e.oflow = 1'b1;
      blks.push_back(e);
    end
  endfunction

  task automatic enqueue(input exp_t blks[$]);
    foreach (blks[i]) exp_q.push_back(blks[i]);
  endtask

  function automatic void seq_key(input int first, input int len, output logic [7:0] key[$]);
    key = {};
    for (int i = 0; i < len; i++) key.push_back(8'(first + i));
  endfunction

  function automatic void rand_key(input int len, output logic [7:0] key[$]);
    key = {};
    for (int i = 0; i < len; i++) key.push_back(8'($urandom_range(255, 0)));
  endfunction

  // out_ready changes just after the rising edge
  initial forever begin
    @(posedge CLK);
    #1;
    case (rdy_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ($urandom_range(3, 0) != 0);
      default: out_ready = 1'b0;
    endcase
  end

  // Block monitor: ordered compare against the model plus stall stability
  logic [109:0] snap;
  bit           prev_stall = 1'b0;
  always @(negedge CLK) begin
    exp_t e;
    if (RST) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid", m_out_valid, 1);
        chk("stall_data", {m_k, m_blen, m_last, m_klen, m_oflow}, snap);
      end
      if (m_out_valid && out_ready) begin
        n_blk++;
        if (exp_q.size() == 0) begin
          fail_now("extra_block: block seen with none expected");
        end else begin
          e = exp_q.pop_front();
          chk("blk_data",  m_k,    e.k);
          chk("blk_blen",  m_blen, 128'(e.blen));
          chk("blk_last",  m_last, 128'(e.last));
          chk("blk_klen",  m_klen, 128'(e.klen));
          chk("blk_oflow", m_oflow, 128'(e.oflow));
        end
      end
      prev_stall = m_out_valid && !out_ready;
      snap       = {m_k, m_blen, m_last, m_klen, m_oflow};
    end
  end

  task automatic send_bytes(input logic [7:0] key[$], input bit mark_last,
                            input int max_gap, output int stalls);
    int wait_cyc;
    stalls = 0;
    foreach (key[i]) begin
      repeat ((max_gap > 0) ? $urandom_range(max_gap, 0) : 0) begin
        @(negedge CLK);
        in_valid = 1'b0;
      end
      @(negedge CLK);
      in_valid = 1'b1;
      in_byte  = key[i];
      in_last  = mark_last && (i == key.size() - 1);
      wait_cyc = 0;
      while (!m_in_ready && wait_cyc < 3000) begin
        @(negedge CLK);
        wait_cyc++;
        stalls++;
      end
      if (!m_in_ready) begin
        fail_now("in_ready_timeout");
        in_valid = 1'b0;
        return;
      end
      n_acc++;
    end
    @(negedge CLK);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_drain();
    int c = 0;
    while (exp_q.size() != 0 && c < 5000) begin
      @(negedge CLK);
      c++;
    end
    if (exp_q.size() != 0) fail_now("drain_timeout");
    repeat (5) @(negedge CLK);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] key[$];
    exp_t       blks[$];
    int         stalls;
    int         b0;

    repeat (3) @(negedge CLK);
    RST = 1'b0;
    for (int g = 0; g < NDUT; g++) begin
      chk("rst_out_valid", d_out_valid[g], 0);
      chk("rst_in_ready",  d_in_ready[g], 1);
    end
    chk("rst_data",  m_k, 0);
    chk("rst_hdr",   {m_blen, m_last, m_klen, m_oflow}, 0);

    // "abc": single last block one cycle after the third byte
    rdy_mode = 0;
    key = '{8'h61, 8'h62, 8'h63};
    model_blocks(key, 250, blks);
    chk("s1_model_n", blks.size(), 1);
    chk("s1_model_k", blks[0].k, 96'h00000000_00000000_00636261);
    chk("s1_model_hdr", {blks[0].blen, blks[0].last, blks[0].klen, blks[0].oflow},
        {32'd3, 1'b1, 32'd3, 1'b0});
    enqueue(blks);
    b0 = n_blk;
    send_bytes(key, 1, 0, stalls);
    chk("s1_latency_valid", m_out_valid, 1);
    chk("s1_k0", d_k0[0], 32'h00636261);
    chk("s1_klen", m_klen, 3);
    wait_drain();
    chk("s1_blocks", n_blk - b0, 1);

    // Exactly 12 bytes: one full last block, no empty follower
    seq_key(1, 12, key);
    model_blocks(key, 250, blks);
    chk("s2_model_n", blks.size(), 1);
    chk("s2_model_k", blks[0].k, 96'h0C0B0A09_08070605_04030201);
    chk("s2_model_hdr", {blks[0].blen, blks[0].last, blks[0].klen},
        {32'd12, 1'b1, 32'd12});
    enqueue(blks);
    b0 = n_blk;
    send_bytes(key, 1, 0, stalls);
    wait_drain();
    chk("s2_blocks", n_blk - b0, 1);

    // 13 bytes back to back: 12 + 1, never stalls
    seq_key(1, 13, key);
    model_blocks(key, 250, blks);
    chk("s3_model_n", blks.size(), 2);
    chk("s3_model_b0", {blks[0].blen, blks[0].last, blks[0].klen}, {32'd12, 1'b0, 32'd0});
    chk("s3_model_b1", {blks[1].k, blks[1].blen, blks[1].klen}, {96'h0D, 32'd1, 32'd13});
    enqueue(blks);
    b0 = n_blk;
    send_bytes(key, 1, 0, stalls);
    chk("s3_stalls", stalls, 0);
    wait_drain();
    chk("s3_blocks", n_blk - b0, 2);

    // 30 bytes with the sink stalled: input stops after byte 24
    seq_key(8'h40, 30, key);
    model_blocks(key, 250, blks);
    chk("s4_model_last", {blks[2].blen, blks[2].last, blks[2].klen}, {32'd6, 1'b1, 32'd30});
    enqueue(blks);
    b0 = n_blk;
    n_acc = 0;
    rdy_mode = 2;
    fork
      send_bytes(key, 1, 0, stalls);
      begin
        repeat (40) @(negedge CLK);
        chk("s4_bytes_before_stall", n_acc, 24);
        chk("s4_in_ready_low", m_in_ready, 0);
        chk("s4_out_valid_held", m_out_valid, 1);
        rdy_mode = 0;
      end
    join
    wait_drain();
    chk("s4_blocks", n_blk - b0, 3);

    // MAXLEN=20: 26 bytes truncated, then a short clean key
    sel = 1;
    seq_key(1, 26, key);
    model_blocks(key, 20, blks);
    chk("s5_model_n", blks.size(), 2);
    chk("s5_model_last", {blks[1].blen, blks[1].last, blks[1].klen, blks[1].oflow},
        {32'd8, 1'b1, 32'd20, 1'b1});
    enqueue(blks);
    send_bytes(key, 1, 0, stalls);
    key = '{8'h61, 8'h62, 8'h63};
    model_blocks(key, 20, blks);
    enqueue(blks);
    send_bytes(key, 1, 0, stalls);
    wait_drain();

    // MAXLEN=24: overflow on a block boundary gives an empty flagged block
    sel = 2;
    seq_key(1, 30, key);
    model_blocks(key, 24, blks);
    chk("s5b_model_n", blks.size(), 3);
    chk("s5b_model_last", {blks[2].k, blks[2].blen, blks[2].klen, blks[2].oflow},
        {96'h0, 32'd0, 32'd24, 1'b1});
    enqueue(blks);
    send_bytes(key, 1, 0, stalls);
    seq_key(8'h80, 24, key);
    model_blocks(key, 24, blks);
    enqueue(blks);
    send_bytes(key, 1, 0, stalls);
    wait_drain();

    // Reset mid-key leaves no residue
    sel = 0;
    seq_key(8'h31, 7, key);
    send_bytes(key, 0, 0, stalls);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    exp_q = {};
    chk("s6_rst_out_valid", m_out_valid, 0);
    chk("s6_rst_in_ready", m_in_ready, 1);
    key = '{8'h61, 8'h62, 8'h63};
    model_blocks(key, 250, blks);
    enqueue(blks);
    b0 = n_blk;
    send_bytes(key, 1, 0, stalls);
    chk("s6_k0", d_k0[0], 32'h00636261);
    wait_drain();
    chk("s6_blocks", n_blk - b0, 1);

    // Randomised keys, gaps and back-pressure on every instance
    for (int g = 0; g < NDUT; g++) begin
      sel = g;
      rdy_mode = 1;
      for (int k = 0; k < 25; k++) begin
        rand_key((g == 0 && k == 10) ? 260 : int'($urandom_range(45, 1)), key);
        model_blocks(key, dut_maxlen(g), blks);
        enqueue(blks);
        send_bytes(key, 1, 2, stalls);
      end
      wait_drain();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
